axi_burst_beat_gen: RTL and testbench
=====================================

// Module: axi_burst_beat_gen
// PURPOSE
//  Expands one AXI AW/AR burst command (addr, len, size, burst, id) into a stream of
//  per-beat descriptors: beat address, byte-lane range and strobe mask.
//  Sits directly downstream of the AXI channel decode in slave-side adapters and memory
//  front-ends, using the axi_pkg burst_t/len_t/size_t encodings and A3-51 beat arithmetic.
//  One beat per cycle after a one-cycle command latency; illegal commands raise an error.
// PARAMETERS
//  AddrWidth  64  address width in bits (beat address arithmetic is modulo 2^AddrWidth)
//  DataWidth  64  bus data width in bits; StrbWidth = DataWidth/8, power of two, >= 8
//  IdWidth    4   AXI ID width carried with each beat
// PORTS
//  clk_i             in   1          clock, all logic on rising edge
//  rst_i             in   1          synchronous, active-high reset
//  cmd_valid_i       in   1          command valid
//  cmd_ready_o       out  1          command ready
//  cmd_addr_i        in   AddrWidth  start address
//  cmd_len_i         in   8          axi_pkg::len_t, beats-1
//  cmd_size_i        in   3          axi_pkg::size_t, bytes/beat = 1<<size
//  cmd_burst_i       in   2          axi_pkg::burst_t
//  cmd_id_i          in   IdWidth    transaction ID
//  beat_valid_o      out  1          beat descriptor valid
//  beat_ready_i      in   1          beat descriptor consumed
//  beat_addr_o       out  AddrWidth  address of this beat
//  beat_idx_o        out  8          beat index, 0..len
//  beat_last_o       out  1          beat_idx_o == len
//  beat_lo_byte_o    out  $clog2(StrbWidth)  lowest active byte lane
//  beat_hi_byte_o    out  $clog2(StrbWidth)  highest active byte lane
//  beat_strb_o       out  StrbWidth  lanes lo..hi set, others clear
//  beat_id_o         out  IdWidth    ID of the owning command
//  err_o             out  1          one-cycle pulse: illegal command dropped
//  err_id_o          out  IdWidth    ID of the dropped command, valid with err_o
// BEHAVIOUR
//  Reset: state IDLE, beat_valid_o=0, err_o=0, all data outputs 0; an in-flight burst is discarded.
//  States: IDLE (cmd_ready_o=1) -> BURST on cmd handshake with a legal command.
//    BURST -> IDLE on handshake of the last beat, unless a new command is accepted the same cycle.
//  cmd_ready_o = (state==IDLE) | (beat_valid_o & beat_ready_i & beat_last_o); no bubble between bursts.
//  Latency: command accepted at edge T -> beat 0 valid after T+1. Throughput: 1 beat/cycle.
//  beat_* stay stable while beat_valid_o & !beat_ready_i; advance only on handshake.
//  Illegal command (accepted, no beats emitted; err_o=1 and err_id_o=cmd_id_i on next cycle, state stays IDLE):
//    burst==2'b11; size > log2(StrbWidth); WRAP with len not in {1,3,7,15}; WRAP with addr not size-aligned.
//  N=1<<size; A=aligned(addr,size)=(addr>>size)<<size.
//  FIXED: every beat addr = cmd addr; lanes of beat 0 are repeated on all beats.
//  INCR: beat 0 addr = cmd addr; beat i addr = A + i*N. 4 KiB crossing is not checked (upstream guarantee).
//  WRAP: T=N*(len+1); B=(addr/T)*T. Next addr = cur+N, and if that equals B+T it becomes B.
//  Lanes: lo = addr mod StrbWidth. Beat 0 (and all FIXED beats): hi = (A mod StrbWidth)+N-1.
//    Other beats: hi = lo+N-1.
//  beat_idx_o counter is 8 bits, no overflow possible (max 255 = len).
//  cmd_* inputs are sampled only on handshake; later changes are ignored.
// TESTING
//  INCR, addr 0x1003, len 3, size 2, DW64 -> addrs 0x1003/0x1004/0x1008/0x100C;
//    strb 0x08/0xF0/0x0F/0xF0; last on beat 3.
//  WRAP, addr 0x38, len 3, size 3 -> addrs 0x38/0x20/0x28/0x30, strb 0xFF each, idx 0..3.
//  FIXED, addr 0x104, len 2, size 1 -> three beats at 0x104, strb 0x30.
//  WRAP with len 2, id 5 -> no beat_valid_o, err_o high exactly 1 cycle with err_id_o=5;
//    next command accepted normally.
//  beat_ready_i low 5 cycles on beat 1 -> outputs stable. Second cmd held valid ->
//    accepted on last-beat handshake, its beat 0 valid next cycle.
//  rst_i asserted mid-burst (beat 2 of 8) -> beat_valid_o=0 next cycle, cmd_ready_o=1, no further beats.

Source files
------------

// File: rtl/axi_burst_beat_gen.sv
// Expands one AXI burst command into per-beat address / byte-lane / strobe descriptors.
// One beat per cycle, beat 0 valid the cycle after the command handshake.
module axi_burst_beat_gen #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int IdWidth = 4,
  localparam int StrbWidth = DataWidth / 8,
  localparam int LaneWidth = $clog2(StrbWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [7:0]           cmd_len_i,
  input  logic [2:0]           cmd_size_i,
  input  logic [1:0]           cmd_burst_i,
  input  logic [IdWidth-1:0]   cmd_id_i,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [AddrWidth-1:0] beat_addr_o,
  output logic [7:0]           beat_idx_o,
  output logic                 beat_last_o,
  output logic [LaneWidth-1:0] beat_lo_byte_o,
  output logic [LaneWidth-1:0] beat_hi_byte_o,
  output logic [StrbWidth-1:0] beat_strb_o,
  output logic [IdWidth-1:0]   beat_id_o,
  output logic                 err_o,
  output logic [IdWidth-1:0]   err_id_o
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  state_t               state_reg, state_next;
  logic [AddrWidth-1:0] addr_reg, addr_next;
  logic [7:0]           idx_reg, idx_next;
  logic [7:0]           len_reg, len_next;
  logic [1:0]           burst_reg, burst_next;
  logic [IdWidth-1:0]   id_reg, id_next;
  logic [AddrWidth-1:0] n_reg, n_next;
  logic [LaneWidth-1:0] nm1_reg, nm1_next;
  logic [AddrWidth-1:0] wrap_mask_reg, wrap_mask_next;
  logic [LaneWidth-1:0] lo_reg, lo_next;
  logic [LaneWidth-1:0] hi_reg, hi_next;
  logic [StrbWidth-1:0] strb_reg, strb_calc;
  logic                 strb_load;
  logic                 err_reg, err_next;
  logic [IdWidth-1:0]   err_id_reg, err_id_next;

  // Command decode
  logic [AddrWidth-1:0] n_cmd;
  logic [AddrWidth-1:0] t_cmd;
  logic [LaneWidth-1:0] nm1_cmd;
  logic [LaneWidth-1:0] a_lane_cmd;
  logic                 wrap_len_ok;
  logic                 cmd_illegal;

  always_comb begin
    n_cmd       = AddrWidth'(1) << cmd_size_i;
    t_cmd       = n_cmd * (AddrWidth'(cmd_len_i) + AddrWidth'(1));
    nm1_cmd     = LaneWidth'((32'd1 << cmd_size_i) - 32'd1);
    a_lane_cmd  = cmd_addr_i[LaneWidth-1:0] & ~nm1_cmd;
    wrap_len_ok = (cmd_len_i == 8'd1) || (cmd_len_i == 8'd3) ||
                  (cmd_len_i == 8'd7) || (cmd_len_i == 8'd15);
    cmd_illegal = (cmd_burst_i == 2'b11) ||
                  (cmd_size_i > 3'(LaneWidth)) ||
                  ((cmd_burst_i == BURST_WRAP) &&
                   (!wrap_len_ok || ((cmd_addr_i & (n_cmd - AddrWidth'(1))) != '0)));
  end

  // Next-beat address; beats after the first are always size-aligned
  logic [AddrWidth-1:0] a_cur;
  logic [AddrWidth-1:0] adv_addr;

  always_comb begin
    a_cur = addr_reg & ~(n_reg - AddrWidth'(1));
    case (burst_reg)
      BURST_INCR: adv_addr = a_cur + n_reg;
      BURST_WRAP: adv_addr = (addr_reg & ~wrap_mask_reg) |
                             ((addr_reg + n_reg) & wrap_mask_reg);
      default:    adv_addr = addr_reg;
    endcase
  end

  logic beat_fire;
  logic is_last;
  logic cmd_fire;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    idx_next       = idx_reg;
    len_next       = len_reg;
    burst_next     = burst_reg;
    id_next        = id_reg;
    n_next         = n_reg;
    nm1_next       = nm1_reg;
    wrap_mask_next = wrap_mask_reg;
    lo_next        = lo_reg;
    hi_next        = hi_reg;
    strb_load      = 1'b0;
    err_next       = 1'b0;
    err_id_next    = err_id_reg;

    is_last     = (idx_reg == len_reg);
    beat_fire   = (state_reg == BURST) && beat_ready_i;
    cmd_ready_o = (state_reg == IDLE) || (beat_fire && is_last);
    cmd_fire    = cmd_valid_i && cmd_ready_o;

    if (cmd_fire && cmd_illegal) begin
      err_next    = 1'b1;
      err_id_next = cmd_id_i;
    end

    if (cmd_fire && !cmd_illegal) begin
      state_next     = BURST;
      addr_next      = cmd_addr_i;
      idx_next       = 8'd0;
      len_next       = cmd_len_i;
      burst_next     = cmd_burst_i;
      id_next        = cmd_id_i;
      n_next         = n_cmd;
      nm1_next       = nm1_cmd;
      wrap_mask_next = t_cmd - AddrWidth'(1);
      lo_next        = cmd_addr_i[LaneWidth-1:0];
      hi_next        = a_lane_cmd + nm1_cmd;
      strb_load      = 1'b1;
    end else if (beat_fire && is_last) begin
      state_next = IDLE;
    end else if (beat_fire) begin
      idx_next  = idx_reg + 8'd1;
      addr_next = adv_addr;
      // FIXED bursts repeat the lanes of beat 0
      if (burst_reg != BURST_FIXED) begin
        lo_next   = adv_addr[LaneWidth-1:0];
        hi_next   = adv_addr[LaneWidth-1:0] + nm1_reg;
        strb_load = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < StrbWidth; gi++) begin : g_strb
    assign strb_calc[gi] = (LaneWidth'(gi) >= lo_next) && (LaneWidth'(gi) <= hi_next);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      idx_reg       <= '0;
      len_reg       <= '0;
      burst_reg     <= '0;
      id_reg        <= '0;
      n_reg         <= '0;
      nm1_reg       <= '0;
      wrap_mask_reg <= '0;
      lo_reg        <= '0;
      hi_reg        <= '0;
      strb_reg      <= '0;
      err_reg       <= 1'b0;
      err_id_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      idx_reg       <= idx_next;
      len_reg       <= len_next;
      burst_reg     <= burst_next;
      id_reg        <= id_next;
      n_reg         <= n_next;
      nm1_reg       <= nm1_next;
      wrap_mask_reg <= wrap_mask_next;
      lo_reg        <= lo_next;
      hi_reg        <= hi_next;
      if (strb_load) begin
        strb_reg <= strb_calc;
      end
      err_reg       <= err_next;
      err_id_reg    <= err_id_next;
    end
  end

  assign beat_valid_o   = (state_reg == BURST);
  assign beat_addr_o    = addr_reg;
  assign beat_idx_o     = idx_reg;
  assign beat_last_o    = (state_reg == BURST) && is_last;
  assign beat_lo_byte_o = lo_reg;
  assign beat_hi_byte_o = hi_reg;
  assign beat_strb_o    = strb_reg;
  assign beat_id_o      = id_reg;
  assign err_o          = err_reg;
  assign err_id_o       = err_id_reg;

endmodule

// File: tb/tb_axi_burst_beat_gen.sv
// Directed and randomized bench for axi_burst_beat_gen against a queue-based burst model.
module tb_axi_burst_beat_gen;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic [IW-1:0] cmd_id;
  logic          beat_valid;
  logic          beat_ready;
  logic [AW-1:0] beat_addr;
  logic [7:0]    beat_idx;
  logic          beat_last;
  logic [2:0]    beat_lo;
  logic [2:0]    beat_hi;
  logic [7:0]    beat_strb;
  logic [IW-1:0] beat_id;
  logic          err;
  logic [IW-1:0] err_id;

  always #5 clk = ~clk;

  axi_burst_beat_gen #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_len_i(cmd_len), .cmd_size_i(cmd_size), .cmd_burst_i(cmd_burst), .cmd_id_i(cmd_id),
    .beat_valid_o(beat_valid), .beat_ready_i(beat_ready), .beat_addr_o(beat_addr),
    .beat_idx_o(beat_idx), .beat_last_o(beat_last), .beat_lo_byte_o(beat_lo),
    .beat_hi_byte_o(beat_hi), .beat_strb_o(beat_strb), .beat_id_o(beat_id),
    .err_o(err), .err_id_o(err_id)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  idx;
    logic        last;
    logic [2:0]  lo;
    logic [2:0]  hi;
    logic [7:0]  strb;
    logic [3:0]  id;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_illegal(input logic [63:0] a, input int l, input int s, input int b);
    logic [63:0] n;
    n = 64'd1 << s;
    if (b == 3 || s > 3) return 1'b1;
    if (b == 2 && !(l == 1 || l == 3 || l == 7 || l == 15)) return 1'b1;
    if (b == 2 && (a % n) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Burst model: addresses and lanes straight from the burst arithmetic rules
  function automatic void build(input logic [63:0] a, input int l, input int s, input int b,
                                input int id);
    logic [63:0] n, al, t, base, cur, ba;
    int lo, hi;
    beat_t bt;
    n = 64'd1 << s;
    al = (a >> s) << s;
    t = n * 64'(l + 1);
    base = (a / t) * t;
    cur = a;
    exp_q.delete();
    for (int i = 0; i <= l; i++) begin
      if (i == 0 || b == 0) ba = a;
      else if (b == 1) ba = al + 64'(i) * n;
      else begin
        ba = cur + n;
        if (ba == base + t) ba = base;
      end
      cur = ba;
      lo = int'(ba % 64'd8);
      hi = (i == 0 || b == 0) ? int'(al % 64'd8) + int'(n) - 1 : lo + int'(n) - 1;
      bt.addr = ba;
      bt.idx = 8'(i);
      bt.last = (i == l);
      bt.lo = 3'(lo);
      bt.hi = 3'(hi);
      bt.strb = '0;
      for (int j = 0; j < 8; j++) bt.strb[j] = (j >= lo && j <= hi);
      bt.id = 4'(id);
      exp_q.push_back(bt);
    end
  endfunction

  task automatic issue(input logic [63:0] a, input int l, input int s, input int b, input int id);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = 8'(l);
    cmd_size  = 3'(s);
    cmd_burst = 2'(b);
    cmd_id    = 4'(id);
  endtask

  task automatic scramble();
    cmd_valid = 1'b0;
    cmd_addr  = {$urandom, $urandom};
    cmd_len   = 8'($urandom);
    cmd_size  = 3'($urandom);
    cmd_burst = 2'($urandom);
    cmd_id    = 4'($urandom);
  endtask

  // Starts and ends at a falling edge; on a legal command leaves the expected beats queued
  task automatic send(input logic [63:0] a, input int l, input int s, input int b, input int id,
                      output bit legal);
    legal = !is_illegal(a, l, s, b);
    issue(a, l, s, b, id);
    beat_ready = 1'b0;
    #1 chk("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    scramble();
    if (legal) begin
      build(a, l, s, b, id);
    end else begin
      #1;
      chk("err_pulse", err, 1'b1);
      chk("err_id", err_id, 64'(id));
      chk("no_beat_on_err", beat_valid, 1'b0);
      @(posedge clk); @(negedge clk);
      #1;
      chk("err_one_cycle", err, 1'b0);
      chk("no_beat_after_err", beat_valid, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic check_beat(input beat_t e);
    chk("beat_valid", beat_valid, 1'b1);
    chk("beat_addr", beat_addr, e.addr);
    chk("beat_idx", beat_idx, e.idx);
    chk("beat_last", beat_last, e.last);
    chk("beat_lo", beat_lo, e.lo);
    chk("beat_hi", beat_hi, e.hi);
    chk("beat_strb", beat_strb, e.strb);
    chk("beat_id", beat_id, e.id);
    chk("err_quiet", err, 1'b0);
  endtask

  // mode 0: always ready, 1: random stalls, 2: five stall cycles on beat 1
  task automatic consume(input int mode, input int limit);
    int stalls;
    for (int k = 0; k < exp_q.size() && k < limit; k++) begin
      stalls = (mode == 2) ? ((k == 1) ? 5 : 0) : (mode == 1) ? int'($urandom_range(0, 2)) : 0;
      for (int c = 0; c <= stalls; c++) begin
        beat_ready = (c == stalls);
        #1;
        check_beat(exp_q[k]);
        chk("cmd_ready_burst", cmd_ready, beat_ready & exp_q[k].last);
        @(posedge clk); @(negedge clk);
      end
      beat_ready = 1'b0;
    end
  endtask

  task automatic expect_idle();
    #1;
    chk("idle_valid", beat_valid, 1'b0);
    chk("idle_ready", cmd_ready, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit legal;
    logic [63:0] ra;
    int rl, rs, rb, rid, rm;

    rst = 1'b1;
    beat_ready = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", beat_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_id", err_id, 64'd0);
    chk("rst_addr", beat_addr, 64'd0);
    chk("rst_idx", beat_idx, 64'd0);
    chk("rst_last", beat_last, 1'b0);
    chk("rst_strb", beat_strb, 64'd0);
    chk("rst_lo_hi", {beat_lo, beat_hi}, 64'd0);
    chk("rst_id", beat_id, 64'd0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // INCR unaligned start
    send(64'h1003, 3, 2, 1, 3, legal);
    consume(0, 256);
    expect_idle();
    // WRAP wrapping to the container base
    send(64'h38, 3, 3, 2, 7, legal);
    consume(0, 256);
    expect_idle();
    // FIXED repeats beat 0
    send(64'h104, 2, 1, 0, 1, legal);
    consume(0, 256);
    expect_idle();
    // Illegal WRAP length, then a normal command
    send(64'h40, 2, 3, 2, 5, legal);
    send(64'h2000, 1, 3, 1, 6, legal);
    consume(0, 256);
    expect_idle();
    // Stall on beat 1 with a second command waiting
    send(64'h3000, 3, 3, 1, 2, legal);
    issue(64'h5006, 2, 1, 1, 9);
    consume(2, 256);
    scramble();
    build(64'h5006, 2, 1, 1, 9);
    consume(0, 256);
    expect_idle();
    // Reset in the middle of an 8-beat burst
    send(64'h7000, 7, 3, 1, 4, legal);
    consume(0, 2);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    #1;
    chk("midrst_valid", beat_valid, 1'b0);
    chk("midrst_ready", cmd_ready, 1'b1);
    chk("midrst_addr", beat_addr, 64'd0);
    chk("midrst_strb", beat_strb, 64'd0);
    rst = 1'b0;
    beat_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      #1 chk("midrst_no_beats", beat_valid, 1'b0);
    end
    beat_ready = 1'b0;
    @(negedge clk);
    // Other illegal encodings
    send(64'h0, 0, 0, 3, 10, legal);
    send(64'h0, 0, 4, 1, 11, legal);
    send(64'h44, 3, 3, 2, 12, legal);

    for (int it = 0; it < 40; it++) begin
      rb = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      if (rb == 2 && $urandom_range(0, 7) != 0) rl = (1 << $urandom_range(1, 4)) - 1;
      else rl = int'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = 64'hFFFF_FFFF_FFFF_FF00 | (ra & 64'hFF);
      if (rb == 2 && rs <= 3 && $urandom_range(0, 7) != 0) ra = (ra >> rs) << rs;
      rid = int'($urandom_range(0, 15));
      rm = int'($urandom_range(0, 1));
      send(ra, rl, rs, rb, rid, legal);
      if (legal) begin
        consume(rm, 256);
        expect_idle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
